// File: rtl/csr_req_arbiter.sv
// Round-robin arbiter sharing one CSR request/response port among NumReq requesters.
// One transaction in flight; request and response paths are both registered.
module csr_req_arbiter #(
    parameter int unsigned NumReq       = 2,
    parameter int unsigned AddrWidth    = 5,
    parameter int unsigned RegDataWidth = 32,
    localparam int unsigned ReqIdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NumReq-1:0][AddrWidth-1:0]     req_addr_i,
    input  logic [NumReq-1:0][RegDataWidth-1:0]  req_wr_data_i,
    input  logic [NumReq-1:0]                    req_wr_en_i,
    input  logic [NumReq-1:0]                    req_valid_i,
    output logic [NumReq-1:0]                    req_ready_o,
    output logic [NumReq-1:0][RegDataWidth-1:0]  rsp_data_o,
    output logic [NumReq-1:0]                    rsp_valid_o,
    input  logic [NumReq-1:0]                    rsp_ready_i,
    output logic [AddrWidth-1:0]                 csr_addr_o,
    output logic [RegDataWidth-1:0]              csr_wr_data_o,
    output logic                                 csr_wr_en_o,
    output logic                                 csr_req_valid_o,
    input  logic                                 csr_req_ready_i,
    input  logic [RegDataWidth-1:0]              csr_rd_data_i,
    input  logic                                 csr_rsp_valid_i,
    output logic                                 csr_rsp_ready_o,
    output logic                                 busy_o,
    output logic [ReqIdxWidth-1:0]               owner_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        RESP     = 2'd3
    } state_e;

    state_e                   state;
    logic [ReqIdxWidth-1:0]   rr_ptr;
    logic [ReqIdxWidth-1:0]   owner_q;
    logic [AddrWidth-1:0]     addr_q;
    logic [RegDataWidth-1:0]  wr_data_q;
    logic                     wr_en_q;
    logic [RegDataWidth-1:0]  rd_data_q;
    logic                     csr_req_valid_q;
    logic                     csr_rsp_ready_q;
    logic [NumReq-1:0]        rsp_valid_q;
    logic                     busy_q;

    logic                     grant_valid;
    logic [ReqIdxWidth-1:0]   grant_idx;
    logic [ReqIdxWidth-1:0]   grant_next_ptr;

    // Round-robin scan starting at rr_ptr, wrapping modulo NumReq.
    always_comb begin
        int unsigned cand;
        logic [ReqIdxWidth-1:0] cand_idx;
        cand        = 0;
        cand_idx    = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            cand = 32'(rr_ptr) + k;
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            cand_idx = ReqIdxWidth'(cand);
            if (!grant_valid && req_valid_i[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign grant_next_ptr = (grant_idx == ReqIdxWidth'(NumReq - 1)) ? '0
                                                                   : grant_idx + ReqIdxWidth'(1);

    // Grant is combinational and only offered in IDLE outside reset.
    always_comb begin
        req_ready_o = '0;
        if (state == IDLE && !rst_i && grant_valid) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            owner_q         <= '0;
            addr_q          <= '0;
            wr_data_q       <= '0;
            wr_en_q         <= 1'b0;
            rd_data_q       <= '0;
            csr_req_valid_q <= 1'b0;
            csr_rsp_ready_q <= 1'b0;
            rsp_valid_q     <= '0;
            busy_q          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        addr_q          <= req_addr_i[grant_idx];
                        wr_data_q       <= req_wr_data_i[grant_idx];
                        wr_en_q         <= req_wr_en_i[grant_idx];
                        owner_q         <= grant_idx;
                        rr_ptr          <= grant_next_ptr;
                        csr_req_valid_q <= 1'b1;
                        busy_q          <= 1'b1;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (csr_req_ready_i) begin
                        csr_req_valid_q <= 1'b0;
                        if (wr_en_q) begin
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            csr_rsp_ready_q <= 1'b1;
                            state           <= WAIT_RSP;
                        end
                    end
                end
                WAIT_RSP: begin
                    if (csr_rsp_valid_i) begin
                        rd_data_q       <= csr_rd_data_i;
                        csr_rsp_ready_q <= 1'b0;
                        rsp_valid_q     <= NumReq'(1) << owner_q;
                        state           <= RESP;
                    end
                end
                RESP: begin
                    // Only the owner lane's ready completes the response.
                    if (rsp_ready_i[owner_q]) begin
                        rsp_valid_q <= '0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign rsp_data_o      = {NumReq{rd_data_q}};
    assign rsp_valid_o     = rsp_valid_q;
    assign csr_addr_o      = addr_q;
    assign csr_wr_data_o   = wr_data_q;
    assign csr_wr_en_o     = wr_en_q;
    assign csr_req_valid_o = csr_req_valid_q;
    assign csr_rsp_ready_o = csr_rsp_ready_q;
    assign busy_o          = busy_q;
    assign owner_o         = owner_q;

endmodule

// File: tb/tb_csr_req_arbiter.sv
// Scoreboard bench for csr_req_arbiter: directed stimulus pushes expected downstream
// requests and upstream responses; monitors pop and compare on each handshake.
module tb_csr_req_arbiter;

    localparam int unsigned NumReq       = 2;
    localparam int unsigned AddrWidth    = 5;
    localparam int unsigned RegDataWidth = 32;

    logic                                clk;
    logic                                rst;
    logic [NumReq-1:0][AddrWidth-1:0]    req_addr;
    logic [NumReq-1:0][RegDataWidth-1:0] req_wr_data;
    logic [NumReq-1:0]                   req_wr_en;
    logic [NumReq-1:0]                   req_valid;
    logic [NumReq-1:0]                   req_ready;
    logic [NumReq-1:0][RegDataWidth-1:0] rsp_data;
    logic [NumReq-1:0]                   rsp_valid;
    logic [NumReq-1:0]                   rsp_ready;
    logic [AddrWidth-1:0]                csr_addr;
    logic [RegDataWidth-1:0]             csr_wr_data;
    logic                                csr_wr_en;
    logic                                csr_req_valid;
    logic                                csr_req_ready;
    logic [RegDataWidth-1:0]             csr_rd_data;
    logic                                csr_rsp_valid;
    logic                                csr_rsp_ready;
    logic                                busy;
    logic [0:0]                          owner;

    typedef struct {
        logic [AddrWidth-1:0]    addr;
        logic [RegDataWidth-1:0] data;
        logic                    wr;
        int                      lane;
    } csr_exp_t;

    typedef struct {
        int                      lane;
        logic [RegDataWidth-1:0] data;
    } rsp_exp_t;

    csr_exp_t exp_csr[$];
    rsp_exp_t exp_rsp[$];

    int checks   = 0;
    int failures = 0;

    csr_req_arbiter #(
        .NumReq       (NumReq),
        .AddrWidth    (AddrWidth),
        .RegDataWidth (RegDataWidth)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .req_addr_i      (req_addr),
        .req_wr_data_i   (req_wr_data),
        .req_wr_en_i     (req_wr_en),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .rsp_data_o      (rsp_data),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .csr_addr_o      (csr_addr),
        .csr_wr_data_o   (csr_wr_data),
        .csr_wr_en_o     (csr_wr_en),
        .csr_req_valid_o (csr_req_valid),
        .csr_req_ready_i (csr_req_ready),
        .csr_rd_data_i   (csr_rd_data),
        .csr_rsp_valid_i (csr_rsp_valid),
        .csr_rsp_ready_o (csr_rsp_ready),
        .busy_o          (busy),
        .owner_o         (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic push_csr(input logic [AddrWidth-1:0] a, input logic [RegDataWidth-1:0] d,
                            input logic w, input int lane);
        csr_exp_t e;
        e.addr = a; e.data = d; e.wr = w; e.lane = lane;
        exp_csr.push_back(e);
    endtask

    task automatic push_rsp(input int lane, input logic [RegDataWidth-1:0] d);
        rsp_exp_t e;
        e.lane = lane; e.data = d;
        exp_rsp.push_back(e);
    endtask

    task automatic drive_req(input int lane, input logic [AddrWidth-1:0] a,
                             input logic [RegDataWidth-1:0] d, input logic w);
        req_addr[lane]    = a;
        req_wr_data[lane] = d;
        req_wr_en[lane]   = w;
        req_valid[lane]   = 1'b1;
    endtask

    // Downstream request monitor.
    always @(negedge clk) begin
        if (!rst && csr_req_valid && csr_req_ready) begin
            if (exp_csr.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL csr_unexpected: got addr 0x%0h expected no request", csr_addr);
            end else begin
                csr_exp_t e;
                e = exp_csr.pop_front();
                check("csr_addr",    64'(csr_addr),    64'(e.addr));
                check("csr_wr_data", 64'(csr_wr_data), 64'(e.data));
                check("csr_wr_en",   64'(csr_wr_en),   64'(e.wr));
                check("csr_owner",   64'(owner),       64'(e.lane));
            end
        end
    end

    // Upstream response monitor.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NumReq; i++) begin
                if (rsp_valid[i] && rsp_ready[i]) begin
                    if (exp_rsp.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rsp_unexpected: got lane %0d expected no response", i);
                    end else begin
                        rsp_exp_t e;
                        e = exp_rsp.pop_front();
                        check("rsp_lane", 64'(i), 64'(e.lane));
                        check("rsp_data", 64'(rsp_data[i]), 64'(e.data));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        req_addr      = '0;
        req_wr_data   = '0;
        req_wr_en     = '0;
        req_valid     = '0;
        rsp_ready     = '0;
        csr_req_ready = 1'b1;
        csr_rd_data   = '0;
        csr_rsp_valid = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        sample();
        check("rst_busy",          64'(busy),          64'd0);
        check("rst_owner",         64'(owner),         64'd0);
        check("rst_csr_req_valid", 64'(csr_req_valid), 64'd0);
        check("rst_csr_rsp_ready", 64'(csr_rsp_ready), 64'd0);
        check("rst_rsp_valid",     64'(rsp_valid),     64'd0);
        check("rst_req_ready",     64'(req_ready),     64'd0);
        step();

        // 1: single write from lane 0
        drive_req(0, 5'd3, 32'hA5, 1'b1);
        push_csr(5'd3, 32'hA5, 1'b1, 0);
        sample();
        check("t1_req_ready", 64'(req_ready), 64'b01);
        step();
        req_valid = '0;
        sample();
        check("t1_csr_valid", 64'(csr_req_valid), 64'd1);
        check("t1_busy",      64'(busy),          64'd1);
        check("t1_req_ready_issue", 64'(req_ready), 64'd0);
        step();
        sample();
        check("t1_idle_busy",  64'(busy),          64'd0);
        check("t1_idle_valid", 64'(csr_req_valid), 64'd0);
        check("t1_no_rsp",     64'(rsp_valid),     64'd0);
        step();

        // 2: read from lane 1 with downstream stalls
        csr_req_ready = 1'b0;
        drive_req(1, 5'd9, 32'h0, 1'b0);
        push_csr(5'd9, 32'h0, 1'b0, 1);
        push_rsp(1, 32'hDEADBEEF);
        sample();
        check("t2_req_ready", 64'(req_ready), 64'b10);
        step();
        req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            sample();
            check("t2_stall_valid", 64'(csr_req_valid), 64'd1);
            check("t2_stall_addr",  64'(csr_addr),      64'd9);
            step();
        end
        csr_req_ready = 1'b1;
        sample();
        step();
        for (int c = 0; c < 2; c++) begin
            sample();
            check("t2_wait_rsp_ready", 64'(csr_rsp_ready), 64'd1);
            check("t2_wait_no_rsp",    64'(rsp_valid),     64'd0);
            step();
        end
        csr_rsp_valid = 1'b1;
        csr_rd_data   = 32'hDEADBEEF;
        sample();
        check("t2_rsp_ready_at_r", 64'(csr_rsp_ready), 64'd1);
        step();
        csr_rsp_valid = 1'b0;
        csr_rd_data   = '0;
        rsp_ready     = 2'b01;
        sample();
        check("t2_rsp_valid",   64'(rsp_valid),     64'b10);
        check("t2_rsp_data0",   64'(rsp_data[0]),   64'hDEADBEEF);
        check("t2_rsp_data1",   64'(rsp_data[1]),   64'hDEADBEEF);
        check("t2_rsp_ready_o", 64'(csr_rsp_ready), 64'd0);
        step();
        sample();
        check("t2_rsp_hold", 64'(rsp_valid), 64'b10);
        step();
        rsp_ready = 2'b10;
        sample();
        step();
        rsp_ready = '0;
        sample();
        check("t2_done_busy",  64'(busy),      64'd0);
        check("t2_done_valid", 64'(rsp_valid), 64'd0);
        step();

        // 3: continuous writes on both lanes alternate grants
        drive_req(0, 5'd4, 32'h1111_0000, 1'b1);
        drive_req(1, 5'd5, 32'h2222_0000, 1'b1);
        for (int n = 0; n < 6; n++) begin
            int lane;
            lane = n % 2;
            if (lane == 0) push_csr(5'd4, 32'h1111_0000, 1'b1, 0);
            else           push_csr(5'd5, 32'h2222_0000, 1'b1, 1);
            sample();
            check("t3_grant", 64'(req_ready), 64'(1 << lane));
            step();
            if (n == 5) req_valid = '0;
            sample();
            check("t3_issue_ready", 64'(req_ready),     64'd0);
            check("t3_issue_valid", 64'(csr_req_valid), 64'd1);
            check("t3_owner",       64'(owner),         64'(lane));
            step();
        end

        // 4: stray downstream response is back-pressured in IDLE and ISSUE
        csr_rsp_valid = 1'b1;
        csr_rd_data   = 32'h5555_5555;
        csr_req_ready = 1'b0;
        sample();
        check("t4_idle_rsp_ready", 64'(csr_rsp_ready), 64'd0);
        check("t4_idle_rsp_valid", 64'(rsp_valid),     64'd0);
        step();
        drive_req(0, 5'd7, 32'h77, 1'b1);
        push_csr(5'd7, 32'h77, 1'b1, 0);
        sample();
        check("t4_req_ready", 64'(req_ready), 64'b01);
        step();
        req_valid = '0;
        sample();
        check("t4_issue_rsp_ready", 64'(csr_rsp_ready), 64'd0);
        check("t4_issue_rsp_valid", 64'(rsp_valid),     64'd0);
        step();
        csr_req_ready = 1'b1;
        sample();
        check("t4_hs_rsp_ready", 64'(csr_rsp_ready), 64'd0);
        step();
        csr_rsp_valid = 1'b0;
        csr_rd_data   = '0;
        sample();
        check("t4_done_busy", 64'(busy),      64'd0);
        check("t4_done_rsp",  64'(rsp_valid), 64'd0);
        step();

        // 5: owner stalls the response while lane 1 waits
        drive_req(0, 5'd12, 32'h0, 1'b0);
        push_csr(5'd12, 32'h0, 1'b0, 0);
        push_rsp(0, 32'h0BADF00D);
        push_csr(5'd13, 32'h13, 1'b1, 1);
        sample();
        check("t5_grant0", 64'(req_ready), 64'b01);
        step();
        req_valid[0] = 1'b0;
        drive_req(1, 5'd13, 32'h13, 1'b1);
        sample();
        check("t5_issue_ready", 64'(req_ready), 64'd0);
        step();
        csr_rsp_valid = 1'b1;
        csr_rd_data   = 32'h0BADF00D;
        sample();
        check("t5_wait_ready",   64'(req_ready),     64'd0);
        check("t5_wait_rsp_rdy", 64'(csr_rsp_ready), 64'd1);
        step();
        csr_rsp_valid = 1'b0;
        csr_rd_data   = '0;
        for (int c = 0; c < 4; c++) begin
            sample();
            check("t5_hold_ready", 64'(req_ready), 64'd0);
            check("t5_hold_rsp",   64'(rsp_valid), 64'b01);
            step();
        end
        rsp_ready = 2'b01;
        sample();
        check("t5_hs_ready", 64'(req_ready), 64'd0);
        step();
        rsp_ready = '0;
        sample();
        check("t5_grant1", 64'(req_ready), 64'b10);
        step();
        req_valid = '0;
        sample();
        check("t5_issue1_valid", 64'(csr_req_valid), 64'd1);
        step();
        sample();
        check("t5_done_busy", 64'(busy), 64'd0);
        step();

        // 6: reset during WAIT_RSP abandons the read and clears rr_ptr
        drive_req(0, 5'd20, 32'h0, 1'b0);
        push_csr(5'd20, 32'h0, 1'b0, 0);
        sample();
        check("t6_grant0", 64'(req_ready), 64'b01);
        step();
        req_valid = '0;
        sample();
        step();
        sample();
        check("t6_wait_rsp_ready", 64'(csr_rsp_ready), 64'd1);
        check("t6_wait_busy",      64'(busy),          64'd1);
        step();
        rst = 1'b1;
        sample();
        step();
        rst = 1'b0;
        drive_req(0, 5'd1, 32'h1, 1'b1);
        drive_req(1, 5'd2, 32'h2, 1'b1);
        push_csr(5'd1, 32'h1, 1'b1, 0);
        sample();
        check("t6_busy",          64'(busy),          64'd0);
        check("t6_csr_rsp_ready", 64'(csr_rsp_ready), 64'd0);
        check("t6_csr_req_valid", 64'(csr_req_valid), 64'd0);
        check("t6_rsp_valid",     64'(rsp_valid),     64'd0);
        check("t6_owner",         64'(owner),         64'd0);
        check("t6_grant_lane0",   64'(req_ready),     64'b01);
        step();
        req_valid = '0;
        sample();
        check("t6_issue_valid", 64'(csr_req_valid), 64'd1);
        step();
        sample();
        check("t6_done_busy", 64'(busy), 64'd0);
        step();
        step();

        check("csr_queue_drained", 64'(exp_csr.size()), 64'd0);
        check("rsp_queue_drained", 64'(exp_rsp.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
